// File: rtl/trg_ack_sequencer.sv
// trg_ack_sequencer: drives per-channel TRG pulses, collects ACK replies, reports done/status/timeout/abort
// Ports: BOARD_CLOCK/RST (sync, active-low); START_I/ABORT_I strobes; CH_MASK_I, PULSE_LEN_I, TIMEOUT_I config;
//   ACK_I board acks; TRG_O triggers; BUSY_O, DONE_O, ACK_STATUS_O, TIMEOUT_O, ABORTED_O status.
// Define TRG_ACK_SYNC_EN to put a 2-flop synchronizer on ACK_I; leave it undefined only for acks already on BOARD_CLOCK.
module trg_ack_sequencer #(
  parameter int NCH = 12,
  parameter int TW = 16
) (
  input  logic BOARD_CLOCK,
  input  logic RST,
  input  logic START_I,
  input  logic ABORT_I,
  input  logic [NCH-1:0] CH_MASK_I,
  input  logic [7:0] PULSE_LEN_I,
  input  logic [TW-1:0] TIMEOUT_I,
  input  logic [NCH-1:0] ACK_I,
  output logic [NCH-1:0] TRG_O,
  output logic BUSY_O,
  output logic DONE_O,
  output logic [NCH-1:0] ACK_STATUS_O,
  output logic TIMEOUT_O,
  output logic ABORTED_O
);
  typedef enum logic [1:0] {IDLE, PULSE, WAIT_ACK, DONE} state_t;
  state_t state;
  logic [NCH-1:0] mask, ack_s, acked;
  logic [7:0] pcnt;
  logic [TW-1:0] tmo, tcnt, tnext;
  logic hit, expired;
`ifdef TRG_ACK_SYNC_EN
  logic [NCH-1:0] s1, s2;
  always_ff @(posedge BOARD_CLOCK)
    if (!RST) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ACK_I;
      s2 <= s1;
    end
  assign ack_s = s2;
`else
  assign ack_s = ACK_I;
`endif
  // success looks at this cycle's capture too, so the last ack ends the wait without an extra cycle
  assign acked = ACK_STATUS_O | (ack_s & mask);
  assign hit = acked == mask;
  assign tnext = &tcnt ? tcnt : tcnt + TW'(1);
  assign expired = tmo != '0 && tnext == tmo;
  always_ff @(posedge BOARD_CLOCK)
    if (!RST) begin
      state <= IDLE;
      mask <= '0;
      pcnt <= '0;
      tmo <= '0;
      tcnt <= '0;
      TRG_O <= '0;
      BUSY_O <= 1'b0;
      DONE_O <= 1'b0;
      ACK_STATUS_O <= '0;
      TIMEOUT_O <= 1'b0;
      ABORTED_O <= 1'b0;
    end else begin
      DONE_O <= 1'b0;
      case (state)
        IDLE:
          if (START_I) begin
            mask <= CH_MASK_I;
            pcnt <= PULSE_LEN_I == 8'd0 ? 8'd0 : PULSE_LEN_I - 8'd1;
            tmo <= TIMEOUT_I;
            tcnt <= '0;
            ACK_STATUS_O <= '0;
            TIMEOUT_O <= 1'b0;
            ABORTED_O <= 1'b0;
            BUSY_O <= 1'b1;
            if (CH_MASK_I == '0) begin
              state <= DONE;
              DONE_O <= 1'b1;
            end else begin
              state <= PULSE;
              TRG_O <= CH_MASK_I;
            end
          end
        PULSE: begin
          ACK_STATUS_O <= acked;
          if (ABORT_I) begin
            state <= DONE;
            TRG_O <= '0;
            ABORTED_O <= 1'b1;
            DONE_O <= 1'b1;
          end else if (pcnt == 8'd0) begin
            state <= WAIT_ACK;
            TRG_O <= '0;
          end else pcnt <= pcnt - 8'd1;
        end
        WAIT_ACK: begin
          ACK_STATUS_O <= acked;
          tcnt <= tnext;
          if (ABORT_I || hit || expired) begin
            state <= DONE;
            DONE_O <= 1'b1;
            ABORTED_O <= ABORT_I;
            TIMEOUT_O <= !ABORT_I && !hit;
          end
        end
        default: begin
          state <= IDLE;
          BUSY_O <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_trg_ack_sequencer.sv
// tb_trg_ack_sequencer: directed checks of trg_ack_sequencer
module tb_trg_ack_sequencer;
`ifdef TRG_ACK_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [11:0] ch_mask = '0, ack = '0, trg, ack_status;
  logic [7:0] pulse_len = '0;
  logic [15:0] timeout = '0;
  logic busy, done, timed_out, aborted;
  int pass = 0, total = 0, cyc = 0, ts = 0, trgcnt = 0, dcnt = 0, dat = -1;
  int ack_rel = -1, ack2_rel = -1, abort_rel = -1;
  logic [11:0] ack_val = '0, ack2_val = '0, trg_or = '0;
  trg_ack_sequencer dut (
    .BOARD_CLOCK(clk), .RST(rst), .START_I(start), .ABORT_I(abort),
    .CH_MASK_I(ch_mask), .PULSE_LEN_I(pulse_len), .TIMEOUT_I(timeout), .ACK_I(ack),
    .TRG_O(trg), .BUSY_O(busy), .DONE_O(done), .ACK_STATUS_O(ack_status),
    .TIMEOUT_O(timed_out), .ABORTED_O(aborted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass++;
  endtask
  task automatic tick();
    int rel;
    @(posedge clk);
    cyc++;
    #1;
    if (trg != '0) trgcnt++;
    trg_or |= trg;
    if (done) begin
      dcnt++;
      if (dat < 0) dat = cyc - ts;
    end
    rel = cyc - ts;
    if (rel == ack_rel) ack = ack_val;
    if (rel == ack2_rel) ack = ack2_val;
    abort = rel == abort_rel;
  endtask
  task automatic sched(input int ar, input logic [11:0] av, input int a2r, input logic [11:0] a2v, input int abr);
    ack_rel = ar;
    ack_val = av;
    ack2_rel = a2r;
    ack2_val = a2v;
    abort_rel = abr;
  endtask
  task automatic run(input logic [11:0] m, input logic [7:0] l, input logic [15:0] t);
    ack = '0;
    ch_mask = m;
    pulse_len = l;
    timeout = t;
    trgcnt = 0;
    dcnt = 0;
    dat = -1;
    trg_or = '0;
    ts = cyc + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int i = 0;
    while (busy && i < 300) begin
      tick();
      i++;
    end
    chk(tag, busy, 1'b0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_trg", trg, 12'h000);
    chk("rst_flags", {busy, done, timed_out, aborted}, 4'b0000);
    chk("rst_status", ack_status, 12'h000);
    rst = 1'b1;
    tick();
    // single-channel success
    sched(9, 12'h001, -1, '0, -1);
    run(12'h001, 8'd4, 16'd100);
    chk("t1_busy", busy, 1'b1);
    wait_idle("t1_idle");
    chk("t1_trgcnt", trgcnt, 4);
    chk("t1_trgval", trg_or, 12'h001);
    chk("t1_done_at", dat, 10 + SL);
    chk("t1_dcnt", dcnt, 1);
    chk("t1_status", ack_status, 12'h001);
    chk("t1_flags", {timed_out, aborted}, 2'b00);
    // partial ack then timeout
    sched(0, 12'h03F, -1, '0, -1);
    run(12'hFFF, 8'd1, 16'd20);
    wait_idle("t2_idle");
    chk("t2_done_at", dat, 21);
    chk("t2_status", ack_status, 12'h03F);
    chk("t2_flags", {timed_out, aborted}, 2'b10);
    chk("t2_trgcnt", trgcnt, 1);
    // last ack lands on the timeout cycle: success wins
    sched(0, 12'h001, 10 - SL, 12'h003, -1);
    run(12'h003, 8'd1, 16'd10);
    wait_idle("t3_idle");
    chk("t3_done_at", dat, 11);
    chk("t3_status", ack_status, 12'h003);
    chk("t3_flags", {timed_out, aborted}, 2'b00);
    // same cycle plus abort: abort wins
    sched(0, 12'h001, 10 - SL, 12'h003, 10);
    run(12'h003, 8'd1, 16'd10);
    wait_idle("t3b_idle");
    chk("t3b_done_at", dat, 11);
    chk("t3b_flags", {timed_out, aborted}, 2'b01);
    // len 0 acts as len 1
    sched(-1, '0, -1, '0, -1);
    run(12'h00A, 8'd0, 16'd5);
    wait_idle("t4_idle");
    chk("t4_trgcnt", trgcnt, 1);
    chk("t4_done_at", dat, 6);
    chk("t4_flags", {timed_out, aborted}, 2'b10);
    // mask 0 completes immediately
    run(12'h000, 8'd5, 16'd5);
    wait_idle("t5_idle");
    chk("t5_done_at", dat, 0);
    chk("t5_dcnt", dcnt, 1);
    chk("t5_trgcnt", trgcnt, 0);
    // start during pulse is ignored
    sched(8, 12'h001, -1, '0, -1);
    run(12'h001, 8'd6, 16'd0);
    tick();
    ch_mask = 12'hFFF;
    pulse_len = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("t6_idle");
    chk("t6_trgcnt", trgcnt, 6);
    chk("t6_trgval", trg_or, 12'h001);
    chk("t6_done_at", dat, 9 + SL);
    chk("t6_dcnt", dcnt, 1);
    // abort mid-pulse
    sched(-1, '0, -1, '0, 9);
    run(12'h0F0, 8'd50, 16'd0);
    wait_idle("t7_idle");
    chk("t7_trgcnt", trgcnt, 10);
    chk("t7_trgval", trg_or, 12'h0F0);
    chk("t7_done_at", dat, 10);
    chk("t7_dcnt", dcnt, 1);
    chk("t7_flags", {timed_out, aborted}, 2'b01);
    // reset during wait
    sched(0, 12'h001, -1, '0, -1);
    run(12'h003, 8'd1, 16'd0);
    repeat (5) tick();
    chk("t8_pre_status", ack_status, 12'h001);
    chk("t8_pre_busy", busy, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t8_rst_trg", trg, 12'h000);
    chk("t8_rst_flags", {busy, done, timed_out, aborted}, 4'b0000);
    chk("t8_rst_status", ack_status, 12'h000);
    sched(0, 12'hFFF, -1, '0, -1);
    run(12'h005, 8'd2, 16'd0);
    wait_idle("t8_idle");
    chk("t8_status", ack_status, 12'h005);
    chk("t8_done_at", dat, 3);
    chk("t8_trgcnt", trgcnt, 2);
    chk("t8_dcnt", dcnt, 1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
